// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants and derived sync windows, shared with the renderers.
// Compile-time only: no latency, no backpressure.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// 1-bit shift register that realigns sync with the renderer pipeline.
// Latency DEPTH cycles (DEPTH=0 is a wire); free-running, no backpressure.
module sync_delay_line #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = vga_clk ^ reset_n;
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0] stages;

        // Every stage resets inactive so no sync pulse escapes right after reset.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                stages <= {DEPTH{RESET_VAL}};
            end else begin
                stages <= (stages << 1) | DEPTH'(d);
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster counters, blank/strobe decode, frame counter and delayed hs/vs.
// Outputs registered (sync +SYNC_DELAY cycles); free-running, no backpressure.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int SYNC_DELAY = 2,
    parameter int FRAME_W    = 8
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output coord_t             DrawX,
    output coord_t             DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0) begin : g_bad_timing
        $error("vga_timing_controller: totals must fit 10-bit counters, SYNC_DELAY >= 0");
    end

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    coord_t x_nxt, y_nxt;
    logic   blank_nxt, hs_nxt, vs_nxt, line_nxt, frame_nxt;
    logic   hs_raw, vs_raw;

    always_comb begin
        x_nxt = DrawX + coord_t'(1);
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
        end
    end

    // Decode from next-state values so every registered output lines up with DrawX/DrawY.
    always_comb begin
        blank_nxt = (int'(x_nxt) < H_VISIBLE) && (int'(y_nxt) < V_VISIBLE);
        hs_nxt    = !((int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END));
        vs_nxt    = !((int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END));
        line_nxt  = (x_nxt == '0);
        frame_nxt = (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= blank_nxt;
            hs_raw      <= hs_nxt;
            vs_raw      <= vs_nxt;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
            if (frame_nxt) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_hs_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (hs_raw),
        .q       (hs)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_vs_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (vs_raw),
        .q       (vs)
    );

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: full-size timing (SYNC_DELAY=0) next to a
// shrunken raster (SYNC_DELAY=2), both checked every cycle against a model.
module tb_vga_timing_controller;

    // index 0: default 640x480 timing; index 1: 16x10 raster
    localparam int HT [2]  = '{800, 16};
    localparam int VT [2]  = '{525, 10};
    localparam int HV [2]  = '{640, 8};
    localparam int VV [2]  = '{480, 6};
    localparam int HSS[2]  = '{656, 10};
    localparam int HSE[2]  = '{752, 13};
    localparam int VSS[2]  = '{490, 7};
    localparam int VSE[2]  = '{492, 9};
    localparam int SD [2]  = '{0, 2};
    localparam int FRAME1  = 16 * 10;

    logic vga_clk, reset_n;

    logic [9:0] DrawX0, DrawY0, DrawX1, DrawY1;
    logic       blank0, hs0, vs0, ls0, fs0;
    logic       blank1, hs1, vs1, ls1, fs1;
    logic [7:0] fc0, fc1;
    logic [32:0] vec0, vec1;

    assign vec0 = {DrawX0, DrawY0, blank0, hs0, vs0, ls0, fs0, fc0};
    assign vec1 = {DrawX1, DrawY1, blank1, hs1, vs1, ls1, fs1, fc1};

    vga_timing_controller #(.SYNC_DELAY(0), .FRAME_W(8)) dut0 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX0),
        .DrawY       (DrawY0),
        .blank       (blank0),
        .hs          (hs0),
        .vs          (vs0),
        .line_start  (ls0),
        .frame_start (fs0),
        .frame_count (fc0)
    );

    vga_timing_controller #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_DELAY(2), .FRAME_W(8)
    ) dut1 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX1),
        .DrawY       (DrawY1),
        .blank       (blank1),
        .hs          (hs1),
        .vs          (vs1),
        .line_start  (ls1),
        .frame_start (fs1),
        .frame_count (fc1)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] pack(int x, int y, bit b, bit h, bit v, bit l, bit f, int fc);
        return {10'(x), 10'(y), b, h, v, l, f, 8'(fc)};
    endfunction

    // reference model state and scoreboard queues
    int mx[2], my[2], mfc[2];
    bit hq0[$], hq1[$], vq0[$], vq1[$];
    logic [32:0] eq0[$], eq1[$];
    int step_idx;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k]  = HT[k] - 1;
            my[k]  = VT[k] - 1;
            mfc[k] = 0;
        end
        hq0.delete(); vq0.delete(); hq1.delete(); vq1.delete();
        eq0.delete(); eq1.delete();
        for (int i = 0; i < SD[0]; i++) begin hq0.push_back(1'b1); vq0.push_back(1'b1); end
        for (int i = 0; i < SD[1]; i++) begin hq1.push_back(1'b1); vq1.push_back(1'b1); end
    endtask

    task automatic model_step(input int k);
        bit b, hraw, vraw, l, f, hd, vd;
        if (mx[k] == HT[k] - 1) begin
            mx[k] = 0;
            my[k] = (my[k] == VT[k] - 1) ? 0 : my[k] + 1;
        end else begin
            mx[k] = mx[k] + 1;
        end
        b    = (mx[k] < HV[k]) && (my[k] < VV[k]);
        hraw = !((mx[k] >= HSS[k]) && (mx[k] < HSE[k]));
        vraw = !((my[k] >= VSS[k]) && (my[k] < VSE[k]));
        l    = (mx[k] == 0);
        f    = l && (my[k] == 0);
        if (f) mfc[k] = (mfc[k] + 1) % 256;
        if (k == 0) begin
            hq0.push_back(hraw); vq0.push_back(vraw);
            hd = hq0.pop_front(); vd = vq0.pop_front();
            eq0.push_back(pack(mx[k], my[k], b, hd, vd, l, f, mfc[k]));
        end else begin
            hq1.push_back(hraw); vq1.push_back(vraw);
            hd = hq1.pop_front(); vd = vq1.pop_front();
            eq1.push_back(pack(mx[k], my[k], b, hd, vd, l, f, mfc[k]));
        end
    endtask

    // one clock: expectations pushed at the edge, DUT compared on the falling edge
    task automatic step();
        logic [32:0] e;
        @(posedge vga_clk);
        model_step(0);
        model_step(1);
        @(negedge vga_clk);
        e = eq0.pop_front();
        check_eq("sb_dut0", 64'(vec0), 64'(e));
        e = eq1.pop_front();
        check_eq("sb_dut1", 64'(vec1), 64'(e));
        step_idx++;
    endtask

    localparam logic [32:0] RST0  = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    localparam logic [32:0] RST1  = {10'd15,  10'd9,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    localparam logic [32:0] FIRST = {10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0_low, h0_first, h1_low, h1_first, v1_low;
        int fs_cnt, last_fs, wrap_cnt, guard;
        logic [7:0] prev_fc1;

        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_eq("rst_dut0", 64'(vec0), 64'(RST0));
        check_eq("rst_dut1", 64'(vec1), 64'(RST1));

        reset_n  = 1'b1;
        step_idx = 0;
        h0_low = 0; h0_first = -1; h1_low = 0; h1_first = -1; v1_low = 0;
        fs_cnt = 0; last_fs = -1; wrap_cnt = 0;
        prev_fc1 = fc1;

        for (int i = 0; i < 256 * FRAME1; i++) begin
            step();
            if (i == 0) begin
                check_eq("first_edge_dut0", 64'(vec0), 64'(FIRST));
                check_eq("first_edge_dut1", 64'(vec1), 64'(FIRST));
            end
            if (i < 2) check_eq("no_early_sync1", 64'({hs1, vs1}), 64'(2'b11));
            if (i == 640) begin
                check_eq("x640_drawx", 64'(DrawX0), 64'(640));
                check_eq("x640_blank", 64'(blank0), 64'(0));
            end
            if (i == 800) check_eq("line_wrap_dut0", 64'({DrawX0, DrawY0, ls0}), 64'({10'd0, 10'd1, 1'b1}));
            if (i < 800 && !hs0) begin
                h0_low++;
                if (h0_first < 0) h0_first = i;
            end
            if (i < 16 && !hs1) begin
                h1_low++;
                if (h1_first < 0) h1_first = i;
            end
            if (i >= FRAME1 && i < 2 * FRAME1 && !vs1) v1_low++;
            if (fs1) begin
                if (last_fs >= 0) check_eq("frame_period", 64'(i - last_fs), 64'(FRAME1));
                last_fs = i;
                fs_cnt++;
            end
            if (prev_fc1 == 8'd255 && fc1 == 8'd0) begin
                wrap_cnt++;
                check_eq("fc_wrap_pos", 64'({DrawX1, DrawY1, fs1, ls1}), 64'({10'd0, 10'd0, 1'b1, 1'b1}));
            end
            prev_fc1 = fc1;
        end

        check_eq("hs0_width",  64'(h0_low),   64'(96));
        check_eq("hs0_start",  64'(h0_first), 64'(656));
        check_eq("hs1_width",  64'(h1_low),   64'(3));
        check_eq("hs1_start",  64'(h1_first), 64'(12));
        check_eq("vs1_width",  64'(v1_low),   64'(32));
        check_eq("frame_cnt",  64'(fs_cnt),   64'(256));
        check_eq("fc_wraps",   64'(wrap_cnt), 64'(1));
        check_eq("fc_end",     64'(fc1),      64'(0));

        // walk into the delayed hs/vs low window, then reset asynchronously
        guard = 0;
        while (!(mx[1] == 13 && my[1] == 8) && guard < 200) begin
            step();
            guard++;
        end
        check_eq("reach_mid_frame", 64'(guard < 200), 64'(1));
        check_eq("pre_rst_sync1", 64'({hs1, vs1}), 64'(2'b00));
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_dut0", 64'(vec0), 64'(RST0));
        check_eq("async_rst_dut1", 64'(vec1), 64'(RST1));
        model_reset();
        @(negedge vga_clk);
        check_eq("held_rst_dut1", 64'(vec1), 64'(RST1));
        reset_n = 1'b1;
        for (int i = 0; i < 3 * FRAME1; i++) begin
            step();
            if (i == 0) begin
                check_eq("restart_dut0", 64'(vec0), 64'(FIRST));
                check_eq("restart_dut1", 64'(vec1), 64'(FIRST));
            end
            if (i < 2) check_eq("restart_no_sync1", 64'({hs1, vs1}), 64'(2'b11));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
